// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and the funct3 legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ACCESS    = 2'd1,
      S_WRITEBACK = 2'd2,
      S_DONE      = 2'd3
   } lsu_state_t;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational byte-lane formatting: load sign/zero extension and the
// read-modify-write merge used for SB/SH.
module lsu_lane_fmt
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic unused_wdata_hi;
   assign unused_wdata_hi = ^wdata[31:16];

   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{24{rdata[7]}}, rdata[7:0]};
         F3_BU:   load_data = {24'h0, rdata[7:0]};
         F3_H:    load_data = {{16{rdata[15]}}, rdata[15:0]};
         F3_HU:   load_data = {16'h0, rdata[15:0]};
         default: load_data = rdata;
      endcase
   end

   // funct3[0] separates SH (001) from SB (000).
   always_comb begin
      merge_data = {rdata[31:8], wdata[7:0]};
      if (funct3[0]) merge_data = {rdata[31:16], wdata[15:0]};
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-write-only data memory; SB/SH
// use read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_AW      = 6,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; the core holds the request stable until then.
   // resp_valid is a single-cycle pulse and is never back-pressured.

   lsu_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] wdata_q, wdata_d;
   logic        fault_q, fault_d;
   logic        mem_we_d, resp_valid_d, resp_fault_d;
   logic [31:0] mem_addr_d, mem_wdata_d, resp_rdata_d;
   logic [31:0] load_data, merge_data;
   logic        misalign, req_fault;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:MEM_AW];
   assign req_ready      = (state_q == S_IDLE);
   assign dbg_state      = state_q;

   lsu_lane_fmt u_lane_fmt (
      .funct3     (f3_q),
      .rdata      (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_fault = !is_legal_f3(req_we, req_funct3) || misalign;

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      wdata_d      = wdata_q;
      fault_d      = fault_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_rdata_d = resp_rdata;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               f3_d       = req_funct3;
               wdata_d    = req_wdata;
               fault_d    = req_fault;
               mem_addr_d = {{(32 - MEM_AW){1'b0}}, req_addr[MEM_AW-1:0]};
               // SW writes straight through during ACCESS, so its strobe is armed now.
               if (req_we && (req_funct3 == F3_W) && !req_fault) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata;
               end
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (fault_q) begin
               resp_valid_d = 1'b1;
               resp_fault_d = 1'b1;
               state_d      = S_DONE;
            end else if (!we_q) begin
               resp_rdata_d = load_data;
               resp_valid_d = 1'b1;
               state_d      = S_DONE;
            end else if (f3_q == F3_W) begin
               resp_valid_d = 1'b1;
               state_d      = S_DONE;
            end else begin
               mem_we_d    = 1'b1;
               mem_wdata_d = merge_data;
               state_d     = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         wdata_q    <= 32'h0;
         fault_q    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         resp_valid <= 1'b0;
         resp_fault <= 1'b0;
         resp_rdata <= RESET_RDATA;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         wdata_q    <= wdata_d;
         fault_q    <= fault_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         resp_valid <= resp_valid_d;
         resp_fault <= resp_fault_d;
         resp_rdata <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed 64-byte memory model.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] mem_b [64];
   logic [5:0] ma;

   load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .dbg_state  (dbg_state)
   );

   // Clock / memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ma        = mem_addr[5:0];
   assign mem_rdata = {mem_b[ma + 6'd3], mem_b[ma + 6'd2], mem_b[ma + 6'd1], mem_b[ma]};

   always @(posedge clk) begin
      if (mem_we) begin
         mem_b[ma]        <= mem_wdata[7:0];
         mem_b[ma + 6'd1] <= mem_wdata[15:8];
         mem_b[ma + 6'd2] <= mem_wdata[23:16];
         mem_b[ma + 6'd3] <= mem_wdata[31:24];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request, then sample each cycle after the accept edge until resp_valid.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [7:0] we_mask,
                         output logic flt, output logic [31:0] rd);
      int w;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      lat = 0; we_mask = 8'h0; flt = 1'b0; rd = 32'h0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         we_mask[c] = mem_we;
         if (resp_valid) begin
            lat = c;
            flt = resp_fault;
            rd  = resp_rdata;
            break;
         end
      end
      if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_vec(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [7:0] exp_mask,
                          input logic exp_flt, input logic [31:0] exp_rd);
      int lat;
      logic [7:0] msk;
      logic flt;
      logic [31:0] rd;
      do_req(we, f3, addr, wd, lat, msk, flt, rd);
      check({tag, ".lat"},   32'(lat), 32'(exp_lat));
      check({tag, ".we"},    {24'h0, msk}, {24'h0, exp_mask});
      check({tag, ".fault"}, {31'h0, flt}, {31'h0, exp_flt});
      check({tag, ".rdata"}, rd, exp_rd);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
      {mem_b[7], mem_b[6], mem_b[5], mem_b[4]}   = 32'h8899_AABC;
      {mem_b[11], mem_b[10], mem_b[9], mem_b[8]} = 32'hDEAD_BEEF;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst.ready",      {31'h0, req_ready},  32'd1);
      check("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
      check("rst.resp_fault", {31'h0, resp_fault}, 32'd0);
      check("rst.mem_we",     {31'h0, mem_we},     32'd0);
      check("rst.mem_addr",   mem_addr,            32'h0);
      check("rst.mem_wdata",  mem_wdata,           32'h0);
      check("rst.rdata",      resp_rdata,          32'h0);
      check("rst.state",      {30'h0, dbg_state},  32'd0);
      rst_n = 1'b1;

      // Loads: sign/zero extension
      run_vec("lb",  1'b0, 3'b000, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'hFFFF_FFBC);
      run_vec("lbu", 1'b0, 3'b100, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'h0000_00BC);
      run_vec("lh",  1'b0, 3'b001, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'hFFFF_AABC);
      run_vec("lhu", 1'b0, 3'b101, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'h0000_AABC);
      run_vec("lw",  1'b0, 3'b010, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'h8899_AABC);

      // Stores: RMW for SB/SH, direct for SW; resp_rdata holds across stores
      run_vec("sb4",  1'b1, 3'b000, 32'd4, 32'h1234_5677, 3, 8'h04, 1'b0, 32'h8899_AABC);
      run_vec("lw4",  1'b0, 3'b010, 32'd4, 32'h0, 2, 8'h00, 1'b0, 32'h8899_AA77);
      run_vec("sh8",  1'b1, 3'b001, 32'd8, 32'h0000_CAFE, 3, 8'h04, 1'b0, 32'h8899_AA77);
      run_vec("lw8",  1'b0, 3'b010, 32'd8, 32'h0, 2, 8'h00, 1'b0, 32'hDEAD_CAFE);
      run_vec("sw12", 1'b1, 3'b010, 32'd12, 32'hA5A5_A5A5, 2, 8'h02, 1'b0, 32'hDEAD_CAFE);
      run_vec("lw12", 1'b0, 3'b010, 32'd12, 32'h0, 2, 8'h00, 1'b0, 32'hA5A5_A5A5);
      run_vec("lw_hi_addr", 1'b0, 3'b010, 32'h1000_000C, 32'h0, 2, 8'h00, 1'b0, 32'hA5A5_A5A5);

      // Illegal funct3
      run_vec("ill_st", 1'b1, 3'b100, 32'd16, 32'hFFFF_FFFF, 2, 8'h00, 1'b1, 32'hA5A5_A5A5);
      run_vec("ill_ld", 1'b0, 3'b011, 32'd4, 32'h0, 2, 8'h00, 1'b1, 32'hA5A5_A5A5);
      run_vec("lw16",   1'b0, 3'b010, 32'd16, 32'h0, 2, 8'h00, 1'b0, 32'h0000_0000);
      run_vec("sw0",    1'b1, 3'b010, 32'd0, 32'h1122_3344, 2, 8'h02, 1'b0, 32'h0000_0000);

      // Misaligned and wrapping accesses
`ifdef LSU_MISALIGN_TRAP_EN
      run_vec("lw5",   1'b0, 3'b010, 32'd5, 32'h0, 2, 8'h00, 1'b1, 32'h0000_0000);
      run_vec("lw62",  1'b0, 3'b010, 32'd62, 32'h0, 2, 8'h00, 1'b1, 32'h0000_0000);
      run_vec("lhu9",  1'b0, 3'b101, 32'd9, 32'h0, 2, 8'h00, 1'b1, 32'h0000_0000);
      run_vec("sw13",  1'b1, 3'b010, 32'd13, 32'h0, 2, 8'h00, 1'b1, 32'h0000_0000);
`else
      run_vec("lw5",   1'b0, 3'b010, 32'd5, 32'h0, 2, 8'h00, 1'b0, 32'hFE88_99AA);
      run_vec("lw62",  1'b0, 3'b010, 32'd62, 32'h0, 2, 8'h00, 1'b0, 32'h3344_0000);
      run_vec("lhu9",  1'b0, 3'b101, 32'd9, 32'h0, 2, 8'h00, 1'b0, 32'h0000_ADCA);
`endif
      run_vec("lw12b", 1'b0, 3'b010, 32'd12, 32'h0, 2, 8'h00, 1'b0, 32'hA5A5_A5A5);

      // Reset during WRITEBACK of an SB abandons the write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'd12; req_wdata = 32'h0000_0000;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rmw.access_we", {31'h0, mem_we}, 32'd0);
      @(negedge clk);
      check("rmw.wb_we", {31'h0, mem_we}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rmw.rst_we",    {31'h0, mem_we},    32'd0);
      check("rmw.rst_state", {30'h0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rmw.ready", {31'h0, req_ready}, 32'd1);
      run_vec("lw12c", 1'b0, 3'b010, 32'd12, 32'h0, 2, 8'h00, 1'b0, 32'hA5A5_A5A5);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
